// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: registers the ALU result, runs the data-memory req/ack
// handshake for loads/stores and emits one registered write-back beat per instruction.
module ex_mem_stage #(
  parameter int WIDTH         = 32,
  parameter int REGADDR_WIDTH = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  input  logic                     ex_valid_i,
  input  logic [WIDTH-1:0]         alu_result_i,
  input  logic [WIDTH-1:0]         store_data_i,
  input  logic [REGADDR_WIDTH-1:0] rd_addr_i,
  input  logic                     mem_read_i,
  input  logic                     mem_write_i,
  input  logic                     reg_write_i,
  input  logic                     flush_i,
  output logic                     stall_o,
  output logic                     dmem_req_o,
  output logic                     dmem_we_o,
  output logic [WIDTH-1:0]         dmem_addr_o,
  output logic [WIDTH-1:0]         dmem_wdata_o,
  input  logic                     dmem_ack_i,
  input  logic [WIDTH-1:0]         dmem_rdata_i,
  output logic                     wb_valid_o,
  output logic                     wb_reg_write_o,
  output logic [REGADDR_WIDTH-1:0] wb_rd_addr_o,
  output logic [WIDTH-1:0]         wb_data_o,
  output logic                     misalign_o
);

  typedef enum logic [1:0] {EMPTY, ALU_OP, MEM_WAIT} state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic [WIDTH-1:0]           r_addr;
  logic [WIDTH-1:0]           r_wdata;
  logic [REGADDR_WIDTH-1:0]   r_rd;
  logic                       r_mem_write;
  logic                       r_reg_write;
  logic                       r_misalign;
  logic                       w_capture;
  logic                       w_mem_op;
  logic                       w_aligned;
  logic                       w_ack;

  assign w_mem_op  = mem_read_i || mem_write_i;
  assign w_aligned = (alu_result_i[1:0] == 2'b00);
  assign w_capture = ex_valid_i && !flush_i && !stall_o;
  assign w_ack     = (r_state == MEM_WAIT) && dmem_ack_i;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = EMPTY;
    stall_o      = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    if (r_state == MEM_WAIT) begin
      stall_o    = !dmem_ack_i;
      dmem_req_o = 1'b1;
      dmem_we_o  = r_mem_write;
    end
    // A stalled access keeps the stage busy; otherwise the slot refills or empties.
    if (w_capture) begin
      w_state_next = (w_mem_op && w_aligned) ? MEM_WAIT : ALU_OP;
    end else if (stall_o) begin
      w_state_next = MEM_WAIT;
    end
  end

  assign dmem_addr_o  = {r_addr[WIDTH-1:2], 2'b00};
  assign dmem_wdata_o = r_wdata;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd        <= '0;
      r_mem_write <= 1'b0;
      r_reg_write <= 1'b0;
      r_misalign  <= 1'b0;
    end else if (w_capture) begin
      r_addr      <= alu_result_i;
      r_wdata     <= store_data_i;
      r_rd        <= rd_addr_i;
      r_mem_write <= mem_write_i;
      r_reg_write <= reg_write_i;
      r_misalign  <= w_mem_op && !w_aligned;
    end
  end

  // wb_* payload holds its last value between beats; only the strobes clear.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_o     <= 1'b0;
      wb_reg_write_o <= 1'b0;
      wb_rd_addr_o   <= '0;
      wb_data_o      <= '0;
      misalign_o     <= 1'b0;
    end else if (r_state == ALU_OP) begin
      wb_valid_o     <= 1'b1;
      wb_reg_write_o <= r_reg_write && !r_misalign;
      wb_rd_addr_o   <= r_rd;
      wb_data_o      <= r_addr;
      misalign_o     <= r_misalign;
    end else if (w_ack) begin
      wb_valid_o     <= 1'b1;
      wb_reg_write_o <= !r_mem_write;
      wb_rd_addr_o   <= r_rd;
      wb_data_o      <= r_mem_write ? r_addr : dmem_rdata_i;
      misalign_o     <= 1'b0;
    end else begin
      wb_valid_o     <= 1'b0;
      misalign_o     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: driver models pipeline acceptance and memory
// latency at instruction level; a separate monitor checks every write-back beat.
module tb_ex_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic [31:0] alu_result_i = '0;
  logic [31:0] store_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic        reg_write_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic        wb_valid_o;
  logic        wb_reg_write_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;

  ex_mem_stage #(.WIDTH(32), .REGADDR_WIDTH(5)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .ex_valid_i(ex_valid_i), .alu_result_i(alu_result_i),
    .store_data_i(store_data_i), .rd_addr_i(rd_addr_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .reg_write_i(reg_write_i), .flush_i(flush_i),
    .stall_o(stall_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o), .wb_reg_write_o(wb_reg_write_o),
    .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    int          due;
  } beat_t;

  beat_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          edge_cnt = 0;
  int          beats = 0;
  logic [31:0] last_data = '0;

  // Instruction-level memory model: one outstanding access with a preset wait count.
  bit          busy = 0;
  int          wait_left = 0;
  logic [31:0] cur_addr = '0;
  logic [31:0] cur_wdata = '0;
  logic [31:0] cur_rdata = '0;
  logic        cur_we = 1'b0;

  always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // One EX slot: drive at negedge, check combinational/memory outputs, update model.
  task automatic step(input logic v, input logic fl, input logic [31:0] alu,
                      input logic [31:0] sd, input logic [4:0] rd, input logic mr,
                      input logic mw, input logic rw, input int wt, input logic [31:0] rdat);
    logic  ack;
    logic  m_stall;
    beat_t e;
    ack          = busy ? (wait_left == 0) : 1'($urandom % 2);
    dmem_ack_i   = ack;
    dmem_rdata_i = (busy && ack) ? cur_rdata : $urandom;
    ex_valid_i   = v;
    flush_i      = fl;
    alu_result_i = alu;
    store_data_i = sd;
    rd_addr_i    = rd;
    mem_read_i   = mr;
    mem_write_i  = mw;
    reg_write_i  = rw;
    #1;
    m_stall = busy && !ack;
    chk("stall", 32'(stall_o), 32'(m_stall));
    chk("dmem_req", 32'(dmem_req_o), 32'(busy));
    if (busy) begin
      chk("dmem_addr", dmem_addr_o, cur_addr & 32'hFFFF_FFFC);
      chk("dmem_we", 32'(dmem_we_o), 32'(cur_we));
      if (cur_we) chk("dmem_wdata", dmem_wdata_o, cur_wdata);
    end
    if (busy && ack) busy = 0;
    else if (busy) wait_left--;
    if (v && !fl && !m_stall) begin
      e.due = edge_cnt + 2;
      e.rd  = rd;
      e.mis = 1'b0;
      if ((mr || mw) && alu[1:0] != 2'b00) begin
        e.mis = 1'b1; e.rw = 1'b0; e.data = '0;
      end else if (mr || mw) begin
        busy = 1; wait_left = wt; cur_addr = alu; cur_wdata = sd;
        cur_rdata = rdat; cur_we = mw;
        e.due  = edge_cnt + 2 + wt;
        e.rw   = mr;
        e.data = mw ? alu : rdat;
      end else begin
        e.rw = rw; e.data = alu;
      end
      exp_q.push_back(e);
    end
    @(negedge clk_i);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, $urandom, $urandom, 5'($urandom), 1'b0, 1'b0, 1'b0, 0, '0);
  endtask

  always @(negedge clk_i) begin
    beat_t e;
    if (!rst_n) begin
      last_data = '0;
    end else if (wb_valid_o) begin
      beats++;
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL unexpected_beat: got data %h rd %0d, expected no beat", wb_data_o, wb_rd_addr_o);
      end else begin
        e = exp_q.pop_front();
        chk("beat_edge", 32'(edge_cnt), 32'(e.due));
        chk("misalign", 32'(misalign_o), 32'(e.mis));
        chk("wb_reg_write", 32'(wb_reg_write_o), 32'(e.rw));
        if (!e.mis) begin
          chk("wb_rd", 32'(wb_rd_addr_o), 32'(e.rd));
          chk("wb_data", wb_data_o, e.data);
        end
      end
      last_data = wb_data_o;
    end else begin
      chk("idle_misalign", 32'(misalign_o), 32'd0);
      chk("idle_hold_data", wb_data_o, last_data);
    end
  end

  initial begin
    #1;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(dmem_req_o), 32'd0);
    chk("rst_we", 32'(dmem_we_o), 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_wdata", dmem_wdata_o, 32'd0);
    chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    chk("rst_wb_rw", 32'(wb_reg_write_o), 32'd0);
    chk("rst_wb_rd", 32'(wb_rd_addr_o), 32'd0);
    chk("rst_wb_data", wb_data_o, 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    @(negedge clk_i); @(negedge clk_i);
    rst_n = 1'b1;

    // ALU-only stream
    step(1, 0, 32'd5, 0, 5'd1, 0, 0, 1, 0, 0);
    step(1, 0, 32'd7, 0, 5'd2, 0, 0, 1, 0, 0);
    step(1, 0, 32'd9, 0, 5'd3, 0, 0, 1, 0, 0);
    repeat (2) idle();
    // Load with two wait cycles
    step(1, 0, 32'h0000_0104, 0, 5'd4, 1, 0, 1, 2, 32'hDEAD_BEEF);
    repeat (4) idle();
    // Back-to-back store then load
    step(1, 0, 32'h10, 32'hA5, 5'd5, 0, 1, 0, 0, 0);
    step(1, 0, 32'h14, 0, 5'd6, 1, 0, 1, 0, 32'h1234_5678);
    repeat (2) idle();
    // Misaligned load
    step(1, 0, 32'h6, 0, 5'd7, 1, 0, 1, 0, 0);
    repeat (2) idle();
    // Flush during stall
    step(1, 0, 32'h200, 0, 5'd8, 1, 0, 1, 3, 32'hCAFE_F00D);
    step(1, 1, 32'h33, 0, 5'd9, 0, 0, 1, 0, 0);
    step(1, 1, 32'h44, 0, 5'd10, 0, 0, 1, 0, 0);
    repeat (4) idle();
    // Reset mid-access
    step(1, 0, 32'h300, 0, 5'd11, 1, 0, 1, 6, 32'h5555_AAAA);
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(dmem_req_o), 32'd0);
    chk("midrst_stall", 32'(stall_o), 32'd0);
    chk("midrst_wb_valid", 32'(wb_valid_o), 32'd0);
    busy = 0;
    exp_q.delete();
    @(negedge clk_i); @(negedge clk_i);
    rst_n = 1'b1;
    repeat (4) idle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      int op;
      a  = $urandom;
      op = $urandom % 3;
      if ($urandom % 4 != 0) a[1:0] = 2'b00;
      step(1'($urandom % 4 != 0), 1'($urandom % 8 == 0), a, $urandom, 5'($urandom),
           1'(op == 1), 1'(op == 2), 1'($urandom % 2), $urandom_range(0, 3), $urandom);
    end

    for (int i = 0; i < 20 && (exp_q.size() != 0 || busy); i++) idle();
    idle();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(busy), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

EX/MEM pipeline stage sitting directly downstream of the ALU in the pipelined CPU. It registers the ALU result together with the store data and write-back control, and drives the data-memory request/acknowledge handshake for loads and stores. While an access is outstanding it stalls the earlier stages. On completion it presents a single registered write-back beat to the MEM/WB side.

## Interface
- `WIDTH`, 32: datapath width; matches the ALU result width.
- `REGADDR_WIDTH`, 5: destination register index width.
- `clk_i`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid_i`  in  1  EX holds a valid instruction this cycle.
- `alu_result_i`  in  WIDTH  ALU result: memory byte address for loads/stores, write-back value otherwise.
- `store_data_i`  in  WIDTH  forwarded rt value for stores.
- `rd_addr_i`  in  REGADDR_WIDTH  destination register.
- `mem_read_i`, `mem_write_i`, `reg_write_i`  in  1 each  decoded control; `mem_read_i` and `mem_write_i` are never both 1.
- `flush_i`  in  1  kill the instruction presented this cycle (branch redirect).
- `stall_o`  out  1  hold EX and earlier stages.
- `dmem_req_o`  out  1  memory request.
- `dmem_we_o`  out  1  1 = store.
- `dmem_addr_o`  out  WIDTH  word-aligned address.
- `dmem_wdata_o`  out  WIDTH  store data.
- `dmem_ack_i`  in  1  access complete.
- `dmem_rdata_i`  in  WIDTH  load data, valid with ack.
- `wb_valid_o`  out  1  one-cycle write-back beat.
- `wb_reg_write_o`  out  1  register write enable for that beat.
- `wb_rd_addr_o`  out  REGADDR_WIDTH  destination register for that beat.
- `wb_data_o`  out  WIDTH  write-back value for that beat.
- `misalign_o`  out  1  one-cycle pulse: load/store dropped due to `alu_result_i[1:0] != 0`.

## Operation
- States: EMPTY, ALU_OP, MEM_WAIT.
- **Capture.** Capture happens on an edge where `ex_valid_i && !flush_i && !stall_o`. It latches result, store data, rd and control into the stage register.
- **Next state after capture:**
  - MEM_WAIT if the instruction is a load/store with an aligned address.
  - ALU_OP otherwise, including a misaligned memory op.
- **No capture:** next state is EMPTY.
- **Misaligned memory op:**
  - Treated as a bubble: no memory request.
  - `misalign_o` pulses together with a `wb_valid_o` beat carrying `wb_reg_write_o=0`.
- **Memory handshake in MEM_WAIT:**
  - `dmem_req_o=1`; `dmem_we_o`, `dmem_addr_o`, `dmem_wdata_o` are held stable from the stage register until the ack is sampled.
  - `dmem_addr_o = {addr[WIDTH-1:2], 2'b00}`.
- **Stall:** `stall_o = (state==MEM_WAIT) && !dmem_ack_i` (combinational).
  - When ack is high, stall drops in the same cycle, so a new instruction may be captured on the same edge the access completes (back-to-back memory ops, no bubble).
- `dmem_ack_i` is ignored outside MEM_WAIT.
- **Write-back register (all fields registered):**
  - ALU_OP: beat issued on the following edge; `wb_data_o` = ALU result; `wb_reg_write_o` = captured `reg_write_i`.
  - MEM_WAIT with ack: beat issued on the ack edge.
    - Load: `wb_data_o = dmem_rdata_i`, write enabled.
    - Store: `wb_reg_write_o=0`, `wb_data_o` = address.
  - `wb_*` fields keep their last value when `wb_valid_o=0`; only `wb_valid_o` and `misalign_o` return to 0.
- **Flush:**
  - Affects only the instruction being presented.
  - Never aborts an outstanding access.
  - A flush during a stall kills the waiting EX instruction; the in-flight access still completes and retires.

## Timing
- **Reset (async, immediate):** state EMPTY; every output is 0, including `dmem_req_o`, `stall_o`, `wb_valid_o`, `misalign_o` and all data/address outputs.
- **Reset mid-access:** request is dropped at once; the access is not retried after reset release.
- **Latency from capture edge N:**
  - ALU op: beat at edge N+1.
  - Memory op with ack in the first MEM_WAIT cycle: beat at edge N+1.
  - Each additional ack wait cycle adds one cycle.
- Throughput: one instruction per cycle when memory acks immediately.
- Exactly one `wb_valid_o` beat per captured instruction; none for flushed or non-valid slots.

## Test plan
- **ALU-only stream:** `alu_result_i` = 5, 7, 9 with `reg_write_i=1`, rd = 1, 2, 3 on consecutive cycles -> beats on three consecutive cycles with data 5, 7, 9 and rd 1, 2, 3; `stall_o` never asserted.
- **Load with two wait cycles:** addr 0x0000_0104, ack on the 3rd MEM_WAIT cycle, rdata 0xDEAD_BEEF -> `stall_o=1` for 2 cycles; `dmem_addr_o`=0x104 held; beat `wb_data_o`=0xDEAD_BEEF, `wb_reg_write_o=1`.
- **Back-to-back memory ops:** store to 0x10 (data 0xA5) with ack immediate, then load from 0x14 -> store beat with `wb_reg_write_o=0`, then the load request on the next cycle with no bubble.
- **Misaligned access:** load at 0x0000_0006 -> no `dmem_req_o`; `misalign_o` pulse coincident with a beat carrying `wb_reg_write_o=0`.
- **Flush during stall:** flush asserted while a load waits -> the pending load still retires; the flushed EX instruction produces no beat.
- **Reset mid-access:** `rst_n` low while in MEM_WAIT -> `dmem_req_o`, `stall_o` and `wb_valid_o` go 0 without a clock edge; after release, no request until a new capture.
